// File: rtl/bbus_sequencer_if.sv
// Shared peripheral bus bundle: both requester handshakes plus the external
// chip-side pins (data, address, chip selects, strobes). The sequencer
// uses the slave view; requesters / pin models use the master view.
interface bbus_sequencer_if;
  // W5300 requester
  logic       w_req;
  logic       w_rnw;
  logic [9:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_ack;
  // SL811 requester
  logic       s_req;
  logic       s_rnw;
  logic       s_a0;
  logic [7:0] s_wdata;
  logic       s_ack;
  // shared read-back
  logic [7:0] rdata;
  // external bus pins
  logic [7:0] bd_i;
  logic [7:0] bd_o;
  logic       bd_oe;
  logic [9:0] baddr;
  logic       w5300_cs_n;
  logic       sl811_cs_n;
  logic       brd_n;
  logic       bwr_n;
  logic       busy;

  modport slave (
    input  w_req, w_rnw, w_addr, w_wdata,
    input  s_req, s_rnw, s_a0, s_wdata,
    input  bd_i,
    output w_ack, s_ack, rdata,
    output bd_o, bd_oe, baddr,
    output w5300_cs_n, sl811_cs_n, brd_n, bwr_n, busy
  );

  modport master (
    output w_req, w_rnw, w_addr, w_wdata,
    output s_req, s_rnw, s_a0, s_wdata,
    output bd_i,
    input  w_ack, s_ack, rdata,
    input  bd_o, bd_oe, baddr,
    input  w5300_cs_n, sl811_cs_n, brd_n, bwr_n, busy
  );
endinterface

// File: rtl/bbus_sequencer.sv
// Timed sequencer / arbiter for the shared W5300 + SL811 peripheral bus.
// Each transaction runs IDLE -> SETUP -> STROBE -> HOLD -> GAP with fixed
// per-phase cycle counts; every output is registered.
// Build option: BBUS_RR_ARB_EN selects round-robin arbitration on a tie;
// when undefined, W5300 has fixed priority over SL811.
module bbus_sequencer #(
  parameter int SETUP  = 1,  // 1..15
  parameter int STROBE = 3,  // 1..15
  parameter int HOLD   = 1   // 1..15
) (
  input  logic             clk,
  input  logic             rst,
  bbus_sequencer_if.slave  bus
);

  // Phase counters count down to zero; loading N-1 gives exactly N cycles.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       sel_w;   // 1 = W5300 owns the current transaction
  logic       rnw_q;   // direction frozen at grant

`ifdef BBUS_RR_ARB_EN
  logic       last_w;  // 1 = W5300 was granted most recently
`endif

  // Winner selection and the winner's fields, as seen in the IDLE cycle.
  logic       g_w;
  logic       g_rnw;
  logic [9:0] g_addr;
  logic [7:0] g_wdata;

  // Arbitration and field mux for the requester that would be granted now.
  always_comb begin
    g_w = 1'b0;
`ifdef BBUS_RR_ARB_EN
    if (bus.w_req && bus.s_req) g_w = ~last_w;
    else                        g_w = bus.w_req;
`else
    g_w = bus.w_req;
`endif
    g_rnw   = g_w ? bus.w_rnw   : bus.s_rnw;
    g_addr  = g_w ? bus.w_addr  : {9'd0, bus.s_a0};
    g_wdata = g_w ? bus.w_wdata : bus.s_wdata;
  end

  // Sequencer FSM; outputs are loaded with the values of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      sel_w          <= 1'b0;
      rnw_q          <= 1'b0;
      bus.w5300_cs_n <= 1'b1;
      bus.sl811_cs_n <= 1'b1;
      bus.brd_n      <= 1'b1;
      bus.bwr_n      <= 1'b1;
      bus.bd_oe      <= 1'b0;
      bus.bd_o       <= 8'd0;
      bus.baddr      <= 10'd0;
      bus.rdata      <= 8'd0;
      bus.w_ack      <= 1'b0;
      bus.s_ack      <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef BBUS_RR_ARB_EN
      last_w         <= 1'b0;  // SL811 "last" so W5300 wins the first tie
`endif
    end else begin
      bus.w_ack <= 1'b0;
      bus.s_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.w_req || bus.s_req) begin
            state          <= ST_SETUP;
            cnt            <= SETUP_LD;
            sel_w          <= g_w;
            rnw_q          <= g_rnw;
            bus.busy       <= 1'b1;
            bus.baddr      <= g_addr;
            bus.w5300_cs_n <= ~g_w;
            bus.sl811_cs_n <= g_w;
            bus.bd_oe      <= ~g_rnw;
            if (!g_rnw) bus.bd_o <= g_wdata;
`ifdef BBUS_RR_ARB_EN
            last_w         <= g_w;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            state     <= ST_STROBE;
            cnt       <= STROBE_LD;
            bus.brd_n <= ~rnw_q;
            bus.bwr_n <= rnw_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            // Read data is captured at the edge that closes the strobe.
            if (rnw_q) bus.rdata <= bus.bd_i;
            state     <= ST_HOLD;
            cnt       <= HOLD_LD;
            bus.brd_n <= 1'b1;
            bus.bwr_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            state          <= ST_GAP;
            cnt            <= 4'd0;
            bus.w5300_cs_n <= 1'b1;
            bus.sl811_cs_n <= 1'b1;
            bus.bd_oe      <= 1'b0;
            bus.w_ack      <= sel_w;
            bus.s_ack      <= ~sel_w;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GAP: begin
          // Turnaround cycle: never grants, so the bus idles for one cycle.
          state    <= ST_IDLE;
          cnt      <= 4'd0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= 4'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bbus_sequencer.sv
// Randomized bench for bbus_sequencer. The reference model predicts every
// output per cycle from the transaction timeline (cycle index k relative to
// the grant cycle) and from the arbitration rule.
module tb_bbus_sequencer;

  localparam int S = 1, T = 3, H = 1;
  localparam int N = S + T + H;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  bbus_sequencer_if bif ();
  bbus_sequencer_if bif2 ();

  bbus_sequencer dut (.clk(clk), .rst(rst), .bus(bif));
  bbus_sequencer #(.SETUP(2), .STROBE(1), .HOLD(3)) dut2 (.clk(clk), .rst(rst2), .bus(bif2));

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  logic       m_last_w = 1'b0;
  logic [7:0] m_rdata  = 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_wcs"},   bif.w5300_cs_n, 1);
    chk({pfx, "_scs"},   bif.sl811_cs_n, 1);
    chk({pfx, "_rd"},    bif.brd_n, 1);
    chk({pfx, "_wr"},    bif.bwr_n, 1);
    chk({pfx, "_oe"},    bif.bd_oe, 0);
    chk({pfx, "_bdo"},   bif.bd_o, 0);
    chk({pfx, "_addr"},  bif.baddr, 0);
    chk({pfx, "_rdata"}, bif.rdata, 0);
    chk({pfx, "_wack"},  bif.w_ack, 0);
    chk({pfx, "_sack"},  bif.s_ack, 0);
    chk({pfx, "_busy"},  bif.busy, 0);
  endtask

  // Raise requests (held requests stay high) with fresh fields; IDLE negedge.
  task automatic issue(input logic wr, input logic wrnw, input logic [9:0] wa, input logic [7:0] wd,
                       input logic sr, input logic srnw, input logic sa0, input logic [7:0] sd);
    bif.w_req   = bif.w_req | wr;
    bif.w_rnw   = wrnw;
    bif.w_addr  = wa;
    bif.w_wdata = wd;
    bif.s_req   = bif.s_req | sr;
    bif.s_rnw   = srnw;
    bif.s_a0    = sa0;
    bif.s_wdata = sd;
  endtask

  // Run one transaction from its grant cycle (cycle 0) through the next IDLE.
  task automatic run_txn(input logic [7:0] rdv);
    logic       ww, rnw;
    logic [9:0] addr;
    logic [7:0] wd, rexp;
`ifdef BBUS_RR_ARB_EN
    ww = bif.w_req && (!bif.s_req || !m_last_w);
`else
    ww = bif.w_req;
`endif
    m_last_w = ww;
    rnw  = ww ? bif.w_rnw : bif.s_rnw;
    addr = ww ? bif.w_addr : {9'd0, bif.s_a0};
    wd   = ww ? bif.w_wdata : bif.s_wdata;
    bif.bd_i = 8'($urandom);
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk); @(negedge clk);
      rexp = (rnw && k > S + T) ? rdv : m_rdata;
      chk("busy",  bif.busy, 1);
      chk("wcs_n", bif.w5300_cs_n, !(ww && k <= N));
      chk("scs_n", bif.sl811_cs_n, !(!ww && k <= N));
      chk("brd_n", bif.brd_n, !(rnw && k > S && k <= S + T));
      chk("bwr_n", bif.bwr_n, !(!rnw && k > S && k <= S + T));
      chk("bd_oe", bif.bd_oe, !rnw && k <= N);
      chk("w_ack", bif.w_ack, ww && k == N + 1);
      chk("s_ack", bif.s_ack, !ww && k == N + 1);
      chk("rdata", bif.rdata, rexp);
      if (k <= N) begin
        chk("baddr", bif.baddr, addr);
        if (!rnw) chk("bd_o", bif.bd_o, wd);
      end
      // requester fields wander mid-transaction; they must be ignored
      bif.w_rnw   = 1'($urandom);
      bif.w_addr  = 10'($urandom);
      bif.w_wdata = 8'($urandom);
      bif.s_rnw   = 1'($urandom);
      bif.s_a0    = 1'($urandom);
      bif.s_wdata = 8'($urandom);
      bif.bd_i    = (k == S + T) ? rdv : 8'($urandom);
      if (k == N + 1) begin
        if (ww) bif.w_req = 1'b0;
        else    bif.s_req = 1'b0;
      end
    end
    if (rnw) m_rdata = rdv;
    @(posedge clk); @(negedge clk);
    chk("idle_busy",  bif.busy, 0);
    chk("idle_wcs_n", bif.w5300_cs_n, 1);
    chk("idle_scs_n", bif.sl811_cs_n, 1);
    chk("idle_ack",   {bif.w_ack, bif.s_ack}, 0);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    bif.w_req = 0; bif.s_req = 0; bif.bd_i = 0;
    bif2.w_req = 0; bif2.w_rnw = 0; bif2.w_addr = 0; bif2.w_wdata = 0;
    bif2.s_req = 0; bif2.s_rnw = 0; bif2.s_a0 = 0; bif2.s_wdata = 0; bif2.bd_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); @(negedge clk);

    // W5300 write 2A5 / 5C
    issue(1, 0, 10'h2A5, 8'h5C, 0, 0, 0, 0);
    run_txn(8'h00);
    // SL811 data-register read returning C3
    issue(0, 0, 0, 0, 1, 1, 1, 8'h00);
    run_txn(8'hC3);
    chk("tp_rdata_c3", bif.rdata, 8'hC3);

    // two ties in a row
    issue(1, 1, 10'h155, 8'h11, 1, 0, 0, 8'h22);
    run_txn(8'hA1);
    issue(1, 0, 10'h0F0, 8'h33, 0, 1, 1, 8'h44);
    run_txn(8'hB2);
    if (bif.s_req) run_txn(8'hC4);

    // reset during the strobe of a W5300 read
    issue(1, 1, 10'h3FF, 8'h00, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_strobe", bif.brd_n, 0);
    rst = 1'b1;
    bif.bd_i = 8'h7E;
    @(posedge clk); @(negedge clk);
    chk_reset("mid");
    rst = 1'b0; bif.w_req = 0; bif.s_req = 0;
    m_rdata = 8'd0; m_last_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_ack",  {bif.w_ack, bif.s_ack}, 0);
      chk("post_rst_busy", bif.busy, 0);
    end

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic wr, sr;
      wr = 1'($urandom);
      sr = 1'($urandom);
      if (!wr && !sr && !bif.w_req && !bif.s_req) wr = 1'b1;
      issue(wr, 1'($urandom), 10'($urandom), 8'($urandom),
            sr, 1'($urandom), 1'($urandom), 8'($urandom));
      run_txn(8'($urandom));
    end

    // SETUP=2 STROBE=1 HOLD=3 instance: one write
    bif2.w_req = 1; bif2.w_rnw = 0; bif2.w_addr = 10'h123; bif2.w_wdata = 8'h9A;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      chk("p2_wcs_n",  bif2.w5300_cs_n, !(k <= 6));
      chk("p2_bwr_n",  bif2.bwr_n, !(k == 3));
      chk("p2_brd_n",  bif2.brd_n, 1);
      chk("p2_w_ack",  bif2.w_ack, k == 7);
      chk("p2_busy",   bif2.busy, k <= 7);
      if (k <= 6) chk("p2_baddr", bif2.baddr, 10'h123);
      bif2.w_addr = 10'($urandom);
      if (k == 7) bif2.w_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bbus_sequencer.md
# bbus_sequencer

Timed sequencer and arbiter for the shared peripheral bus (bd, baddr, brd_n, bwr_n) that connects the CPLD to the W5300 and the SL811. Two requesters present level-held transaction requests:
- the W5300 path, which carries memory-window and port accesses after address translation;
- the SL811 path, which carries address and data register accesses.

The block grants one requester at a time and runs a fixed SETUP/STROBE/HOLD cycle with the chip select and strobes. It latches read data and returns a one-cycle ack. It sits between the Z80-side decoders and the external chip pins.

## Interface
Parameters:
- SETUP, default 1: cycles of chip select and address before the strobe; range 1..15.
- STROBE, default 3: cycles brd_n/bwr_n is held low; range 1..15.
- HOLD, default 1: cycles of chip select and address after the strobe rises; range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- w_req  in  1  W5300 request, level-held until w_ack.
- w_rnw  in  1  1 = read, 0 = write.
- w_addr  in  10  W5300 address.
- w_wdata  in  8  W5300 write data.
- w_ack  out  1  one-cycle completion pulse.
- s_req  in  1  SL811 request, level-held until s_ack.
- s_rnw  in  1  1 = read, 0 = write.
- s_a0  in  1  SL811 register select (0 = address register, 1 = data register).
- s_wdata  in  8  SL811 write data.
- s_ack  out  1  one-cycle completion pulse.
- rdata  out  8  latched read data, shared by both requesters.
- bd_i  in  8  bus data input.
- bd_o  out  8  bus data output.
- bd_oe  out  1  bus data output enable.
- baddr  out  10  bus address; SL811 cycles drive {9'd0, s_a0}.
- w5300_cs_n  out  1  W5300 chip select, active-low.
- sl811_cs_n  out  1  SL811 chip select, active-low.
- brd_n  out  1  read strobe, active-low.
- bwr_n  out  1  write strobe, active-low.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
- The counter is 4 bits and reloads on every state entry.
- IDLE: if any req is high, select the winner and register its rnw, address and wdata. Next state is SETUP.
- SETUP: the winner's cs_n is low and baddr is valid. For a write, bd_oe=1 and bd_o=wdata. Stays for SETUP cycles, then goes to STROBE.
- STROBE: brd_n or bwr_n is low, selected by rnw. Stays for STROBE cycles.
  - On the last STROBE cycle of a read, rdata <= bd_i at the closing edge.
  - Then goes to HOLD.
- HOLD: strobes are high. cs_n, baddr, bd_o and bd_oe are unchanged. Stays for HOLD cycles, then goes to GAP.
- GAP: all cs_n are high and bd_oe=0. The granted ack is high for this one cycle. Next state is IDLE.
  - No grant is made in GAP, which gives one bus-turnaround cycle.
  - The requester drops req at the edge that ends GAP. If req is still high in IDLE, it is treated as a new transaction.
- Registered fields are frozen from the grant until the end of GAP. Changes on the requester inputs during a cycle are ignored.
- rdata holds its value until the next read completes. Writes do not alter rdata.
- Arbitration is set by BBUS_RR_ARB_EN (see Configuration).

## Timing
- All outputs are registered.
- Reset values: w5300_cs_n=1, sl811_cs_n=1, brd_n=1, bwr_n=1, bd_oe=0, bd_o=0, baddr=0, rdata=0, w_ack=0, s_ack=0, busy=0. State is IDLE.
- Reset in any state forces the reset values at the next edge. The strobe is aborted and no ack is issued. The round-robin pointer resets so that W5300 is favoured.
- Count cycles from cycle 0, the IDLE cycle in which req is sampled high:
  - cs_n is low in cycles 1..SETUP+STROBE+HOLD.
  - The strobe is low in cycles SETUP+1..SETUP+STROBE.
  - ack is high in cycle SETUP+STROBE+HOLD+1.
- Back-to-back throughput is one transaction per SETUP+STROBE+HOLD+2 cycles.
- With default parameters:
  - cs_n is low in cycles 1–5.
  - The strobe is low in cycles 2–4.
  - ack is high in cycle 6.
  - A new cs_n can be asserted no earlier than cycle 8.
- If both reqs rise in the same IDLE cycle, exactly one is granted. The loser waits with its req held and is granted in the IDLE cycle after GAP.

## Configuration
- BBUS_RR_ARB_EN defined: round-robin arbitration. On a tie, the requester that was not granted last wins. After reset, W5300 wins the first tie.
- BBUS_RR_ARB_EN undefined: fixed priority, W5300 over SL811. SL811 is granted only in an IDLE cycle where w_req=0.

## Test plan
- W5300 write, w_addr=10'h2A5, w_wdata=8'h5C, default parameters:
  - baddr=2A5 and bd_o=5C with bd_oe=1 in cycles 1–5.
  - bwr_n low in cycles 2–4 only.
  - w_ack in cycle 6; sl811_cs_n stays 1.
- SL811 data-register read, s_a0=1, bd_i=8'hC3 during the strobe:
  - baddr=10'h001 and brd_n low in cycles 2–4.
  - rdata=C3 and s_ack high in cycle 6; bd_oe stays 0.
- w_req and s_req asserted together twice in a row:
  - With the macro defined, the grant order is W, S, W, S.
  - With the macro undefined, the grant order is W, W, … while w_req stays held; S follows only when w_req=0.
- rst pulsed during STROBE of a read:
  - The next cycle shows all reset values.
  - No ack is issued and rdata=0.
  - A subsequent request completes normally.
- Parameters SETUP=2, STROBE=1, HOLD=3:
  - Strobe low in cycle 3 only.
  - cs_n low in cycles 1–6 and ack in cycle 7.
- Requester changes w_addr mid-cycle: baddr keeps the value registered at grant until GAP.
